// File: rtl/midori_pkg.sv
// -----------------------------------------------------------------------------
// midori_pkg
//   Shared definitions for the Midori64 I/O sequencer slice: share and width
//   constants, run-length limits, the sequencer state encoding and a small
//   saturating-increment helper used by the cycle watchdog.
// -----------------------------------------------------------------------------
package midori_pkg;

  // Boolean shares per masked value and per-share widths.
  localparam int SHARES = 3;
  localparam int DATA_W = 64;
  localparam int KEY_W  = 128;

  // RUN-cycle window: done is honoured from MIN_CYC_DEF on, the run is
  // abandoned on RUN cycle MAX_CYC_DEF if no done has been seen.
  localparam int MIN_CYC_DEF = 2;
  localparam int MAX_CYC_DEF = 40;

  // Watchdog counter width (holds MAX_CYC_DEF with headroom to saturate).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/midori_cycle_watchdog.sv
// -----------------------------------------------------------------------------
// midori_cycle_watchdog
//   Counts RUN cycles for the sequencer. The count restarts on clear, advances
//   (saturating) while enabled, and decodes the two thresholds the FSM needs.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   clear    in   restart the count at zero
//   enable   in   advance the count this cycle
//   cyc_cnt  out  current RUN-cycle count (saturating)
//   ge_min   out  count has reached MIN_CYC (core_done may be trusted)
//   timeout  out  count is at MAX_CYC-1 (last RUN cycle before giving up)
// -----------------------------------------------------------------------------
module midori_cycle_watchdog
  import midori_pkg::*;
#(
  parameter int MIN_CYC = MIN_CYC_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             ge_min,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX_CYC - 1);

  logic [CNT_W-1:0] cnt_r;

  // RUN-cycle counter: clear wins over enable so LOAD always starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cyc_cnt = cnt_r;
  assign ge_min  = (cnt_r >= MIN_V);
  assign timeout = (cnt_r == LAST_V);

endmodule

// File: rtl/midori_io_sequencer.sv
// -----------------------------------------------------------------------------
// midori_io_sequencer
//   Valid/ready front end for the shared masked Midori64 core. Takes one
//   plaintext/key share set, pulses core_start for one cycle, holds the core
//   inputs stable for the whole run, captures the ciphertext shares on the
//   first trustworthy core_done and offers them on a valid/ready output.
//   Shares are only ever moved as whole vectors, never recombined.
//   A RUN-cycle watchdog abandons a run whose core never signals done and
//   raises a sticky err until the next accepted input.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   input set offered
//   in_ready   out  sequencer can accept (IDLE only)
//   in_pt      in   plaintext shares, share i at [i*DATA_W +: DATA_W]
//   in_key     in   key shares, share i at [i*KEY_W +: KEY_W]
//   core_start out  one-cycle start pulse to the round controller
//   core_pt    out  registered plaintext shares to the core
//   core_key   out  registered key shares to the core
//   core_done  in   done level from the round controller
//   core_ct    in   ciphertext shares from the datapath
//   out_valid  out  ciphertext held and offered
//   out_ready  in   consumer accepts
//   out_ct     out  captured ciphertext shares
//   busy       out  sequencer not IDLE
//   err        out  sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module midori_io_sequencer
  import midori_pkg::*;
#(
  parameter int MIN_CYC = MIN_CYC_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SHARES*DATA_W-1:0] in_pt,
  input  logic [SHARES*KEY_W-1:0]  in_key,
  output logic                     core_start,
  output logic [SHARES*DATA_W-1:0] core_pt,
  output logic [SHARES*KEY_W-1:0]  core_key,
  input  logic                     core_done,
  input  logic [SHARES*DATA_W-1:0] core_ct,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SHARES*DATA_W-1:0] out_ct,
  output logic                     busy,
  output logic                     err
);

  localparam int PT_W = SHARES * DATA_W;
  localparam int K_W  = SHARES * KEY_W;
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX_CYC - 1);

  seq_state_t state_r;
  seq_state_t state_nxt_s;

  logic load_in_s;
  logic capture_s;
  logic err_set_s;
  logic err_clr_s;
  logic wd_clear_s;
  logic wd_enable_s;

  logic [CNT_W-1:0] wd_cnt_s;
  logic             wd_ge_min_s;
  logic             wd_timeout_s;

  logic            in_ready_r;
  logic            core_start_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            err_r;
  logic [PT_W-1:0] core_pt_r;
  logic [K_W-1:0]  core_key_r;
  logic [PT_W-1:0] out_ct_r;

  midori_cycle_watchdog #(
    .MIN_CYC (MIN_CYC),
    .MAX_CYC (MAX_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .cyc_cnt (wd_cnt_s),
    .ge_min  (wd_ge_min_s),
    .timeout (wd_timeout_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_in_s   = 1'b0;
    capture_s   = 1'b0;
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    wd_clear_s  = 1'b0;
    wd_enable_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          load_in_s   = 1'b1;
          err_clr_s   = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        wd_clear_s  = 1'b1;
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        wd_enable_s = 1'b1;
        // A done seen in the first MIN_CYC run cycles may be left over from
        // the previous run, so it only counts once ge_min is up. Capture is
        // checked first so a done on the timeout cycle still delivers.
        if (core_done && wd_ge_min_s) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else if (wd_timeout_s || (wd_cnt_s > LAST_V)) begin
          // The overrun compare also recovers if the counter is ever upset
          // past the timeout value.
          err_set_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake/status outputs, registered from the next state so they line up
  // with the state they describe and carry no combinational path from inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r   <= 1'b1;
      core_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      in_ready_r   <= (state_nxt_s == ST_IDLE);
      core_start_r <= (state_nxt_s == ST_LOAD);
      out_valid_r  <= (state_nxt_s == ST_HOLD);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  // Sticky timeout flag: cleared only by a new accepted input or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (err_clr_s) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Core input share registers: written only on an IDLE acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_pt_r  <= {PT_W{1'b0}};
      core_key_r <= {K_W{1'b0}};
    end else if (load_in_s) begin
      core_pt_r  <= in_pt;
      core_key_r <= in_key;
    end else begin
      core_pt_r  <= core_pt_r;
      core_key_r <= core_key_r;
    end
  end

  // Result share register: written only on a qualifying done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_ct_r <= {PT_W{1'b0}};
    end else if (capture_s) begin
      out_ct_r <= core_ct;
    end else begin
      out_ct_r <= out_ct_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign core_start = core_start_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign err        = err_r;
  assign core_pt    = core_pt_r;
  assign core_key   = core_key_r;
  assign out_ct     = out_ct_r;

endmodule

// File: tb/tb_midori_io_sequencer.sv
// -----------------------------------------------------------------------------
// tb_midori_io_sequencer
//   Directed bench for midori_io_sequencer. A small core model raises done
//   30 cycles after core_start for two cycles with ct = pt ^ A5A5...; stimulus
//   pushes expected ciphertexts into a queue and a separate monitor pops and
//   compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_midori_io_sequencer;
  import midori_pkg::*;

  localparam int PW = SHARES * DATA_W;
  localparam int KW = SHARES * KEY_W;
  localparam logic [63:0] CT_MASK = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] JUNK    = 64'hDEAD_BEEF_0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pt;
  logic [KW-1:0] in_key;
  logic          core_start;
  logic [PW-1:0] core_pt;
  logic [KW-1:0] core_key;
  logic          core_done;
  logic [PW-1:0] core_ct;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_ct;
  logic          busy;
  logic          err;

  midori_io_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pt      (in_pt),
    .in_key     (in_key),
    .core_start (core_start),
    .core_pt    (core_pt),
    .core_key   (core_key),
    .core_done  (core_done),
    .core_ct    (core_ct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ct     (out_ct),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge E (and until the next) cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Core model: k counts cycles since core_start was seen high.
  int   k = 1000;
  logic alive = 1'b1;
  logic stale = 1'b0;
  logic real_done;
  always @(posedge clk) begin
    #1;
    if (core_start) k = 0;
    else if (k < 1000) k = k + 1;
  end
  assign real_done = alive && (k == 30 || k == 31);
  assign core_done = real_done | stale;
  assign core_ct   = real_done ? (core_pt ^ {SHARES{CT_MASK}}) : {SHARES{JUNK}};

  int total = 0;
  int bad   = 0;
  int hs_cyc = -1;
  logic [PW-1:0] exp_q[$];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] mk_pt(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [PW-1:0] mk_ct(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    return {c ^ CT_MASK, b ^ CT_MASK, a ^ CT_MASK};
  endfunction

  // Monitor: every output handshake pops one expected ciphertext.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      hs_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h want no output (cyc %0d)", out_ct, cyc);
      end else begin
        chk_vec("out_ct", KW'(out_ct), KW'(exp_q.pop_front()));
      end
    end
  end

  // Offer one set until accepted; returns the acceptance edge.
  task automatic send(input logic [PW-1:0] pt, input logic [KW-1:0] key,
                      input logic [PW-1:0] exp_ct, input bit push, output int t_acc);
    logic rdy;
    bit   got;
    got      = 1'b0;
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    t_acc    = cyc;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept (cyc %0d)", cyc);
    end else begin
      if (push) exp_q.push_back(exp_ct);
      chk_bit("start_after_accept", core_start, 1'b1);
      chk_bit("busy_after_accept", busy, 1'b1);
      chk_bit("in_ready_load", in_ready, 1'b0);
      chk_vec("core_pt_loaded", KW'(core_pt), KW'(pt));
      chk_vec("core_key_loaded", core_key, key);
    end
  endtask

  // Wait for out_valid; returns the edge after which it was first seen.
  task automatic wait_out(output int t_out);
    bit found;
    found = 1'b0;
    t_out = -1;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) begin
        found = 1'b1;
        t_out = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: got no out_valid want out_valid (cyc %0d)", cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang want finish (cyc %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2, to, ov;
    logic [PW-1:0] pa, pb;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_core_start", core_start, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_err", err, 1'b0);
    chk_vec("rst_out_ct", KW'(out_ct), '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: single op, latency and one-cycle start.
    send(mk_pt(64'd1, 64'd2, 64'd3), {KW{1'b1}}, mk_ct(64'd1, 64'd2, 64'd3), 1'b1, t);
    @(posedge clk);
    #1;
    chk_bit("start_one_cycle", core_start, 1'b0);
    wait_out(to);
    chk_int("t1_latency", to, t + 31);
    chk_bit("t1_err", err, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("t1_out_dropped", out_valid, 1'b0);
    chk_bit("t1_idle_ready", in_ready, 1'b1);

    // 2: output backpressure.
    out_ready = 1'b0;
    pa = mk_pt(64'h0123_4567_89AB_CDEF, 64'h1111, 64'hFFFF_0000_FFFF_0000);
    send(pa, {3{128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100}},
         mk_ct(64'h0123_4567_89AB_CDEF, 64'h1111, 64'hFFFF_0000_FFFF_0000), 1'b1, t);
    wait_out(to);
    for (int i = 0; i < 10; i++) begin
      chk_bit("bp_out_valid", out_valid, 1'b1);
      chk_bit("bp_in_ready", in_ready, 1'b0);
      chk_vec("bp_out_ct", KW'(out_ct),
              KW'(mk_ct(64'h0123_4567_89AB_CDEF, 64'h1111, 64'hFFFF_0000_FFFF_0000)));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("bp_released", out_valid, 1'b0);

    // 3: stale done during LOAD and the first two RUN cycles is ignored.
    send(mk_pt(64'hAAAA, 64'hBBBB, 64'hCCCC), {KW{1'b0}},
         mk_ct(64'hAAAA, 64'hBBBB, 64'hCCCC), 1'b1, t);
    stale = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    stale = 1'b0;
    chk_bit("stale_no_capture", out_valid, 1'b0);
    chk_bit("stale_busy", busy, 1'b1);
    wait_out(to);
    chk_int("t3_latency", to, t + 31);
    @(posedge clk);
    #1;

    // 4: dead core, watchdog timeout then err cleared by next accept.
    alive = 1'b0;
    send(mk_pt(64'd4, 64'd5, 64'd6), {KW{1'b0}}, '0, 1'b0, t);
    ov = 0;
    t2 = -1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) ov++;
      if (err) begin
        t2 = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk_int("timeout_cycle", t2, t + 41);
    chk_int("dead_no_out_valid", ov, 0);
    chk_bit("dead_idle_ready", in_ready, 1'b1);
    chk_bit("dead_not_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("err_sticky", err, 1'b1);
    alive = 1'b1;
    send(mk_pt(64'd7, 64'd8, 64'd9), {KW{1'b1}}, mk_ct(64'd7, 64'd8, 64'd9), 1'b1, t);
    chk_bit("err_cleared", err, 1'b0);
    wait_out(to);
    chk_int("t4_latency", to, t + 31);
    @(posedge clk);
    #1;

    // 5: asynchronous reset in the middle of RUN.
    send(mk_pt(64'hE1, 64'hE2, 64'hE3), {KW{1'b1}}, '0, 1'b0, t);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    chk_bit("mid_rst_core_start", core_start, 1'b0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_in_ready", in_ready, 1'b1);
    chk_bit("mid_rst_out_valid", out_valid, 1'b0);
    chk_vec("mid_rst_core_pt", KW'(core_pt), '0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(mk_pt(64'h51, 64'h52, 64'h53), {KW{1'b0}}, mk_ct(64'h51, 64'h52, 64'h53), 1'b1, t);
    wait_out(to);
    chk_int("t5_latency", to, t + 31);
    @(posedge clk);
    #1;

    // 6: back-to-back with in_valid held; core inputs stay on the first set.
    pa = mk_pt(64'hA0, 64'hA1, 64'hA2);
    pb = mk_pt(64'hB0, 64'hB1, 64'hB2);
    send(pa, {KW{1'b0}}, mk_ct(64'hA0, 64'hA1, 64'hA2), 1'b1, t);
    in_pt    = pb;
    in_key   = {KW{1'b1}};
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_vec("b2b_core_pt_stable", KW'(core_pt), KW'(pa));
    end
    send(pb, {KW{1'b1}}, mk_ct(64'hB0, 64'hB1, 64'hB2), 1'b1, t2);
    chk_int("b2b_first_done", t2 - t, 33);
    chk_int("b2b_restart", t2, hs_cyc + 1);
    wait_out(to);
    chk_int("t6_latency", to, t2 + 31);
    repeat (3) @(posedge clk);
    #1;
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
